// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and the
// parity helper that the receiver uses as well.
package uart_tx_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } tx_state_e;

    // Odd parity makes the total count of ones (data plus parity bit) odd.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic                 odd_n_even);
        logic par;
        if (odd_n_even) begin
            par = ~^data;
        end else begin
            par = ^data;
        end
        return par;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit buffer; pointers carry one extra bit so that full and
// empty are distinguishable without a separate counter.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_wr_data,
    input  logic                          i_pop,
    output logic [DATA_W-1:0]             o_rd_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Pointer update; reset discards every buffered byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array, no reset needed since the pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_rst) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered bytes sent as start, 8 data bits LSB first,
// parity, stop, followed by one idle guard cycle before the next frame.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int ODD_nEVEN  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          UART_clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    tx_state_e             r_state;
    tx_state_e             w_state_next;
    logic [2:0]            r_bit_cnt;
    logic [2:0]            w_bit_cnt_next;
    logic [FRAME_BITS-2:0] r_shift;
    logic [FRAME_BITS-2:0] w_shift_next;
    logic                  r_tx;
    logic                  w_tx_next;
    logic                  r_busy;
    logic                  w_busy_next;
    logic                  r_done;
    logic                  w_done_next;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_BITS-1:0]  w_head;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_BITS)
    ) u_fifo (
        .i_clk     (UART_clk),
        .i_rst     (rst),
        .i_push    (tx_valid),
        .i_wr_data (tx_data),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );

    assign tx_ready     = !w_full;
    assign tx           = r_tx;
    assign tx_busy      = r_busy;
    assign tx_done_tick = r_done;

    // Next-state logic; the shifter holds {stop, parity, data} so everything
    // after the start bit simply shifts out of bit 0.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_tx_next      = 1'b1;
        w_pop          = 1'b0;
        case (r_state)
            IDLE, GAP: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_state_next   = START;
                    w_shift_next   = {1'b1, parity_bit(w_head, 1'(ODD_nEVEN)), w_head};
                    w_bit_cnt_next = 3'd0;
                    w_tx_next      = 1'b0;
                end else begin
                    w_state_next   = IDLE;
                    w_tx_next      = 1'b1;
                end
            end
            START: begin
                w_state_next   = DATA;
                w_tx_next      = r_shift[0];
                w_shift_next   = {1'b1, r_shift[FRAME_BITS-2:1]};
                w_bit_cnt_next = 3'd0;
            end
            DATA: begin
                w_tx_next    = r_shift[0];
                w_shift_next = {1'b1, r_shift[FRAME_BITS-2:1]};
                if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                    w_state_next   = PARITY;
                    w_bit_cnt_next = 3'd0;
                end else begin
                    w_state_next   = DATA;
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                end
            end
            PARITY: begin
                w_state_next = STOP;
                w_tx_next    = r_shift[0];
                w_shift_next = {1'b1, r_shift[FRAME_BITS-2:1]};
            end
            STOP: begin
                w_state_next = GAP;
                w_tx_next    = 1'b1;
            end
            default: begin
                w_state_next   = IDLE;
                w_bit_cnt_next = 3'd0;
                w_tx_next      = 1'b1;
            end
        endcase
        w_busy_next = (w_state_next != IDLE);
        w_done_next = (w_state_next == GAP);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge UART_clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= {(FRAME_BITS-1){1'b1}};
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter ODD_nEVEN, default 1, selects parity: 1 = odd, 0 = even.
REQ-002 Parameter FIFO_DEPTH, default 4, is the transmit buffer depth in bytes; it SHALL be a power of two, 2..16.
REQ-003 Port UART_clk, input, 1, is the single clock; one line bit lasts one UART_clk cycle.
REQ-004 Port rst, input, 1, is the reset: synchronous, active-high.
REQ-005 Port tx_data, input, 8, is the byte to transmit.
REQ-006 Port tx_valid, input, 1, requests a write of tx_data.
REQ-007 Port tx_ready, output, 1, is high when the buffer can accept a byte (not full).
REQ-008 Port tx, output, 1, is the serial line, driven from a register; idle level is 1.
REQ-009 Port tx_busy, output, 1, is high while a frame or its guard cycle is in progress.
REQ-010 Port tx_done_tick, output, 1, is a one-cycle pulse on frame completion.
REQ-011 Port fifo_level, output, $clog2(FIFO_DEPTH)+1, is the number of buffered bytes, excluding the frame in flight.

Function
REQ-012 The frame SHALL be 11 bits: start 0, data[0]..data[7] (LSB first), parity, stop 1.
REQ-013 The parity bit SHALL be XNOR-reduction of the data when ODD_nEVEN=1, and XOR-reduction when ODD_nEVEN=0.
REQ-014 A write SHALL be accepted on a rising edge where tx_valid && tx_ready; otherwise tx_data is ignored.
REQ-015 tx_ready SHALL equal !full and SHALL NOT depend on a same-cycle pop; a write when full is dropped.
REQ-016 A simultaneous push and pop on a non-full, non-empty buffer SHALL leave fifo_level unchanged.
REQ-017 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, GAP; a 3-bit bit counter serves DATA.
REQ-018 IDLE transitions:
- buffer non-empty: pop the head into the shift register and go to START;
- tx is 0 from that edge.
REQ-019 Latency: with the buffer empty and the FSM in IDLE, a byte written at edge k SHALL put the start bit on tx at edge k+1.
REQ-020 Following that start bit:
- data bits at edges k+2..k+9;
- parity at k+10;
- stop at k+11;
- GAP (tx=1) at k+12.
REQ-021 GAP SHALL last exactly one cycle so the receiver completes its post-frame check; the next start bit is no earlier than k+13 (12-cycle frame period).
REQ-022 tx_done_tick SHALL be 1 for exactly the GAP cycle.
REQ-023 tx_busy SHALL be 1 from the START edge through the GAP cycle inclusive, and 0 in IDLE.
REQ-024 With back-to-back buffered bytes, GAP SHALL transition directly to START without an IDLE cycle.
REQ-025 The buffer SHALL wrap its read and write pointers modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL reset as follows:
- tx=1, tx_busy=0, tx_done_tick=0, tx_ready=1, fifo_level=0;
- FSM to IDLE;
- pointers and bit counter to 0.
REQ-027 Reset mid-frame SHALL abort the frame (tx=1 from the reset edge) and discard all buffered bytes; no tx_done_tick is emitted.
REQ-028 Writes presented while rst=1 SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold:
- the state encoding;
- constants FRAME_BITS=11 and DATA_BITS=8;
- the parity function, reused by the receiver.
REQ-030 One sub-module, uart_tx_fifo (synchronous FIFO, parameter FIFO_DEPTH, push/pop/full/empty/level), SHALL be instantiated; the FSM and shifter live in uart_tx.

Verification
REQ-031 Odd parity:
- stimulus: write 0xA5, ODD_nEVEN=1, idle buffer;
- response: tx = 0,1,0,1,0,0,1,0,1,1,1 at edges k+1..k+11, then 1; tx_done_tick at k+12 only.
REQ-032 Even parity:
- stimulus: ODD_nEVEN=0, write 0xA5 then 0x00;
- response: parity bits 0 and 0; second start bit exactly at edge k+13.
REQ-033 Overflow:
- stimulus: 6 consecutive writes (FIFO_DEPTH=4) starting in IDLE;
- response: first pops immediately; 5 accepted; tx_ready low after the 5th; 6th dropped; 5 frames sent, fifo_level decrementing at each START.
REQ-034 Reset mid-frame:
- stimulus: rst=1 at the parity cycle with 2 bytes buffered;
- response: tx=1 next edge; fifo_level=0; no further frames; no tx_done_tick.
REQ-035 Loopback:
- stimulus: tx wired to the team receiver with matching parity, 256 random bytes back-to-back;
- response: every data_out[7:0] matches; PE=FE=0 for all frames.
REQ-036 Concurrent push and pop:
- stimulus: write at the same edge as a GAP-to-START pop with fifo_level=2;
- response: fifo_level stays 2; byte order preserved.
